add_chunked: RTL and testbench

Parametrised multi-cycle adder/subtractor for the CPU datapath. It computes a WIDTH-bit sum or difference CHUNK bits per clock, carrying between chunks in a register. Inputs and outputs use valid/ready handshakes. It serves wide ALU operations where a full-width single-cycle carry chain would not meet timing.

---
 rtl/add_chunked.sv | 129 ++++++++++++
 tb/tb_add_chunked.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_chunked.sv
// add_chunked: multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready high only when idle)
//   a, b, sub, c_in     operands; sub=1 computes a - b - c_in
//   out_valid, out_ready result handshake (out_valid high only when done)
//   sum, c_out, ovf, zero  result, carry out (sub: 1 = no borrow), signed overflow, sum == 0
module add_chunked #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    int unsigned      base;
    logic [CHUNK:0]   chunk_res;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;

        base      = 32'(k_q) * CHUNK;
        chunk_res = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                    + (CHUNK + 1)'(carry_q);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtraction as a + ~b + ~c_in, so the carry out reads as "no borrow".
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~c_in : c_in;
                    k_d     = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[base +: CHUNK] = chunk_res[CHUNK-1:0];
                carry_d              = chunk_res[CHUNK];
                k_d                  = k_q + 1'b1;
                if (k_q == KLAST) begin
                    c_out_d = chunk_res[CHUNK];
                    // Carry into the MSB is recovered from the MSB sum bit and its operands.
                    ovf_d   = chunk_res[CHUNK]
                              ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1]);
                    zero_d  = (sum_d == '0);
                    k_d     = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_add_chunked.sv
// tb_add_chunked: directed, table-driven bench for add_chunked (WIDTH=16).
// Main instance uses CHUNK=4; three more instances (CHUNK=16, 1, 8) share operands.
module tb_add_chunked;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        c_out, ovf, zero;

    logic        sw_valid = 1'b0;
    logic        sw_in_ready [3];
    logic        sw_out_valid [3];
    logic [15:0] sw_sum [3];
    logic        sw_c_out [3];
    logic        sw_ovf [3];
    logic        sw_zero [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_chunked #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    add_chunked #(.WIDTH(16), .CHUNK(16)) dut_c16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[0]),
        .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(sw_out_valid[0]),
        .out_ready(1'b1), .sum(sw_sum[0]), .c_out(sw_c_out[0]), .ovf(sw_ovf[0]),
        .zero(sw_zero[0])
    );

    add_chunked #(.WIDTH(16), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[1]),
        .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(sw_out_valid[1]),
        .out_ready(1'b1), .sum(sw_sum[1]), .c_out(sw_c_out[1]), .ovf(sw_ovf[1]),
        .zero(sw_zero[1])
    );

    add_chunked #(.WIDTH(16), .CHUNK(8)) dut_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[2]),
        .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(sw_out_valid[2]),
        .out_ready(1'b1), .sum(sw_sum[2]), .c_out(sw_c_out[2]), .ovf(sw_ovf[2]),
        .zero(sw_zero[2])
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-width add in 17 bits, overflow from operand/result sign bits.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic msub, input logic mcin);
        logic [15:0] bb;
        logic [16:0] r;
        logic        ov;
        bb = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + {16'd0, msub ? ~mcin : mcin};
        ov = (ma[15] == bb[15]) && (r[15] != ma[15]);
        return {(r[15:0] == 16'd0), ov, r[16], r[15:0]};
    endfunction

    // Accept one operation on the main instance and wait (bounded) for out_valid.
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vsub,
                          input logic vcin, output int lat);
        a = va; b = vb; sub = vsub; c_in = vcin;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int lat;
        int sw_lat [3];
        int exp_lat [3];
        logic [18:0] ref_r;
        logic [15:0] held;

        exp_lat[0] = 1; exp_lat[1] = 16; exp_lat[2] = 2;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst flags", {29'd0, c_out, ovf, zero}, 32'd0);
        rst_n = 1'b1;
        step();

        // Table-driven vectors on CHUNK=4
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd4);
            check($sformatf("v%0d sum", i), 32'(sum), 32'(vecs[i].s));
            check($sformatf("v%0d c_out", i), 32'(c_out), 32'(vecs[i].co));
            check($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].ov));
            check($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].z));
            consume();
            check($sformatf("v%0d in_ready after", i), 32'(in_ready), 32'd1);
            check($sformatf("v%0d out_valid after", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: hold DONE for 10 cycles with changing operands offered
        run_op(16'h1234, 16'h0101, 1'b0, 1'b0, lat);
        check("bp latency", 32'(lat), 32'd4);
        held = sum;
        check("bp sum", 32'(held), 32'h1335);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom); b = 16'($urandom); sub = i[0]; c_in = i[1];
            step();
            check("bp sum held", 32'(sum), 32'h1335);
            check("bp flags held", {29'd0, c_out, ovf, zero}, 32'd0);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume();
        check("bp in_ready after", 32'(in_ready), 32'd1);
        check("bp sum kept in idle", 32'(sum), 32'h1335);

        // Asynchronous reset mid-RUN at k=2
        a = 16'h00FF; b = 16'h0011; sub = 1'b0; c_in = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        check("mid rst sum", 32'(sum), 32'd0);
        #3 rst_n = 1'b1;
        step();
        check("post rst idle", 32'(in_ready), 32'd1);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        check("post rst latency", 32'(lat), 32'd4);
        check("post rst sum", 32'(sum), 32'h2345);
        consume();

        // Parameter sweep: CHUNK=16, 1, 8 against the reference model
        for (int it = 0; it < 4; it++) begin
            a = 16'($urandom); b = 16'($urandom); sub = it[0]; c_in = it[1];
            if (it == 3) begin
                b = a;
            end
            ref_r = model(a, b, sub, c_in);
            for (int d = 0; d < 3; d++) sw_lat[d] = -1;
            sw_valid = 1'b1;
            step();
            sw_valid = 1'b0;
            for (int cyc = 1; cyc <= 20; cyc++) begin
                step();
                for (int d = 0; d < 3; d++) begin
                    if (sw_lat[d] < 0 && sw_out_valid[d]) begin
                        sw_lat[d] = cyc;
                        check($sformatf("sw%0d it%0d result", d, it),
                              {13'd0, sw_zero[d], sw_ovf[d], sw_c_out[d], sw_sum[d]},
                              {13'd0, ref_r});
                    end
                end
            end
            for (int d = 0; d < 3; d++) begin
                check($sformatf("sw%0d it%0d latency", d, it), 32'(sw_lat[d]),
                      32'(exp_lat[d]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
